multi_lane_referee: RTL

MULTI_LANE_REFEREE -- requirements
Module: multi_lane_referee

---
 rtl/game_pkg.sv | 28 ++
 rtl/lane_lfsr.sv | 33 +++
 rtl/multi_lane_referee.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the multi-lane referee.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_INVINC = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int         COORD_W_DEF = 10;
    localparam int         BLK_H_W     = 6;
    localparam logic [5:0] BLK_H_BASE  = 6'd16;

    // Respawn height: 16 + 8*sel, giving 16/24/32/40 pixels.
    function automatic logic [BLK_H_W-1:0] blk_height(input logic [1:0] sel);
        return BLK_H_BASE + {1'b0, sel, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_lfsr.sv
// ============================================================================
// Module      : lane_lfsr
// Description : 8-bit Fibonacci LFSR (taps 8,6,5,4), advances when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [1:0] o_bits
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb   = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
    assign o_bits = r_state[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_lane_referee.sv
// ============================================================================
// Module      : multi_lane_referee
// Description : Side-scroller referee: moves obstacle lanes and the square,
//               detects collisions, tracks lives. REFEREE_SCORE_EN adds o_score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_lane_referee
    import game_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int SCREEN_W     = 640,
    parameter int SQ_X         = 100,
    parameter int SQ_SIZE      = 32,
    parameter int Y_TOP        = 200,
    parameter int Y_FLOOR      = 400,
    parameter int BLK_W        = 32,
    parameter int SPEED        = 4,
    parameter int SPACING      = 160,
    parameter int LIVES        = 3,
    parameter int INVINC_TICKS = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_tick,
    input  logic                       i_start,
    input  logic                       i_jump,
    output logic [LANES*COORD_W-1:0]   o_block_x,
    output logic [LANES*BLK_H_W-1:0]   o_block_h,
    output logic [COORD_W-1:0]         o_square_y,
    output logic [1:0]                 o_lives_left,
    output logic                       o_hurt,
    output logic                       o_invincible,
    output logic                       o_over
`ifdef REFEREE_SCORE_EN
    ,
    output logic [15:0]                o_score
`endif
);

    localparam int XW     = COORD_W + 1;
    localparam int CNT_W  = $clog2(INVINC_TICKS + 1);

    localparam logic [COORD_W-1:0] c_screen_x   = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] c_speed      = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] c_y_top      = COORD_W'(Y_TOP);
    localparam logic [COORD_W-1:0] c_y_floor    = COORD_W'(Y_FLOOR);
    localparam logic [XW-1:0]      c_sq_left    = XW'(SQ_X);
    localparam logic [XW-1:0]      c_sq_right   = XW'(SQ_X + SQ_SIZE);
    localparam logic [XW-1:0]      c_floor_sum  = XW'(Y_FLOOR + SQ_SIZE);
    localparam logic [1:0]         c_lives      = 2'(LIVES);
    localparam logic [CNT_W-1:0]   c_inv_last   = CNT_W'(INVINC_TICKS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [COORD_W-1:0]   r_y;
    logic [COORD_W-1:0]   w_y_next;
    logic [XW-1:0]        w_y_ext;
    logic [1:0]           r_lives;
    logic                 r_hurt;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_start_low;
    logic [LANES-1:0]     w_hit_vec;
    logic                 w_any_hit;
    logic                 w_move;
    logic                 w_hit;
    logic                 w_restart;
`ifdef REFEREE_SCORE_EN
    logic [LANES-1:0]     w_wrap_vec;
    logic [15:0]          r_score;
    logic [4:0]           w_wraps;
    logic [16:0]          w_score_sum;
`endif

    assign w_any_hit = |w_hit_vec;
    assign w_move    = i_tick && ((r_state == ST_RUN) || (r_state == ST_INVINC));
    assign w_hit     = i_tick && (r_state == ST_RUN) && w_any_hit;
    assign w_restart = i_tick && (r_state == ST_OVER) && i_start && r_start_low;
    assign w_y_ext   = {1'b0, r_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_tick && i_start) w_next = ST_RUN;
            ST_RUN:    if (w_hit) w_next = (r_lives > 2'd1) ? ST_INVINC : ST_OVER;
            ST_INVINC: if (i_tick && (r_cnt == c_inv_last)) w_next = ST_RUN;
            ST_OVER:   if (w_restart) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_y_next = r_y;
        if (i_jump) begin
            w_y_next = (w_y_ext < ({1'b0, c_y_top} + XW'(2))) ? c_y_top : r_y - COORD_W'(2);
        end else begin
            w_y_next = ((w_y_ext + XW'(2)) > {1'b0, c_y_floor}) ? c_y_floor : r_y + COORD_W'(2);
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [COORD_W-1:0] c_init_x = COORD_W'(SCREEN_W + i * SPACING);

            logic [COORD_W-1:0] r_x;
            logic [BLK_H_W-1:0] r_h;
            logic [XW-1:0]      w_x_ext;
            logic               w_wrap;
            logic [1:0]         w_bits;

            assign w_x_ext = {1'b0, r_x};
            assign w_wrap  = (r_x < c_speed);

            // Evaluated on registered values so the hit and the move share one TICK.
            assign w_hit_vec[i] = (w_x_ext < c_sq_right) &&
                                  ((w_x_ext + XW'(BLK_W)) > c_sq_left) &&
                                  ((w_y_ext + XW'(SQ_SIZE)) > (c_floor_sum - XW'(r_h)));

            lane_lfsr #(
                .SEED (8'hA5 ^ 8'(i))
            ) u_lfsr (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_move),
                .o_bits (w_bits)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_x <= c_init_x;
                    r_h <= BLK_H_BASE;
                end else if (w_restart) begin
                    r_x <= c_init_x;
                    r_h <= BLK_H_BASE;
                end else if (w_move) begin
                    if (w_wrap) begin
                        r_x <= c_screen_x;
                        r_h <= blk_height(w_bits);
                    end else begin
                        r_x <= r_x - c_speed;
                    end
                end
            end

            assign o_block_x[i*COORD_W +: COORD_W] = r_x;
            assign o_block_h[i*BLK_H_W +: BLK_H_W] = r_h;
`ifdef REFEREE_SCORE_EN
            assign w_wrap_vec[i] = w_move && w_wrap;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= c_y_floor;
            r_lives     <= c_lives;
            r_hurt      <= 1'b0;
            r_cnt       <= '0;
            r_start_low <= 1'b0;
        end else begin
            r_hurt <= w_hit;
            if (w_restart) begin
                r_y     <= c_y_floor;
                r_lives <= c_lives;
            end else begin
                if (w_move) r_y <= w_y_next;
                if (w_hit)  r_lives <= r_lives - 2'd1;
            end
            if (r_state != ST_INVINC) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Re-arming requires START to be seen low on a TICK while in OVER.
            if (r_state != ST_OVER) begin
                r_start_low <= 1'b0;
            end else if (i_tick && !i_start) begin
                r_start_low <= 1'b1;
            end
        end
    end

`ifdef REFEREE_SCORE_EN
    always_comb begin
        w_wraps = '0;
        for (int k = 0; k < LANES; k++) begin
            w_wraps = w_wraps + 5'(w_wrap_vec[k]);
        end
    end

    assign w_score_sum = {1'b0, r_score} + 17'(w_wraps);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (w_score_sum > 17'h0FFFF) begin
            r_score <= 16'hFFFF;
        end else begin
            r_score <= w_score_sum[15:0];
        end
    end

    assign o_score = r_score;
`endif

    assign o_square_y   = r_y;
    assign o_lives_left = r_lives;
    assign o_hurt       = r_hurt;
    assign o_invincible = (r_state == ST_INVINC);
    assign o_over       = (r_state == ST_OVER);

endmodule

`default_nettype wire
